// File: rtl/fsm_pkg.sv
// fsm_pkg: shared state, symbol types and symbol bit masks for the recognizer sequencer
package fsm_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} ctrl_state_t;
  typedef logic [1:0] sym_t;
  localparam sym_t SYM_X = 2'b10;
  localparam sym_t SYM_Z = 2'b01;
endpackage

// File: rtl/fsm_seq_buf.sv
// fsm_seq_buf: append-only symbol register file with length tracking and combinational read
module fsm_seq_buf
  import fsm_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_wr,
  input  sym_t          i_sym,
  input  logic [IW-1:0] i_rd_ptr,
  output sym_t          o_rd_sym,
  output logic [IW:0]   o_len,
  output logic          o_full
);
  sym_t        r_mem [DEPTH];
  logic [IW:0] r_len;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_len <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_len <= '0;
    end else if (i_wr && !o_full) begin
      r_mem[r_len[IW-1:0]] <= i_sym;
      r_len <= r_len + 1'b1;
    end
  assign o_rd_sym = r_mem[i_rd_ptr];
  assign o_len    = r_len;
  assign o_full   = r_len == (IW+1)'(DEPTH);
endmodule

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: buffers a symbol sequence, replays it into a recognizer FSM and scores its y output
module fsm_seq_ctrl
  import fsm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LAT = 2,
  parameter int CW = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  sym_t          i_wr_sym,
  input  logic          i_clr,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_fsm_y,
  output logic          o_fsm_x,
  output logic          o_fsm_z,
  output logic          o_fsm_rst,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_aborted,
  output logic [CW-1:0] o_hit_cnt,
  output logic [IW-1:0] o_first_hit,
  output logic          o_hit_valid,
  output logic          o_wr_err
);
  ctrl_state_t    r_state, w_nxt;
  logic [IW-1:0]  r_ptr, w_ptr_nxt;
  logic [IW-1:0]  r_pi [LAT];
  logic [LAT-1:0] r_pv;
  logic [1:0]     r_dcnt, w_dcnt_nxt;
  logic [IW:0]    w_len, w_len_eff;
  sym_t           w_rd_sym;
  logic           w_full, w_idle, w_clr, w_wr, w_go, w_abort, w_score;

  assign w_idle    = r_state == IDLE;
  assign w_clr     = w_idle && i_clr;
  assign w_wr      = w_idle && i_wr_en && !i_clr && !w_full;
  assign w_go      = w_idle && i_start;
  assign w_abort   = i_abort && (r_state inside {CLEAR, RUN, DRAIN});
  // a write issued alongside start is part of the run
  assign w_len_eff = w_clr ? '0 : w_len + {{IW{1'b0}}, w_wr};
  assign w_score   = r_pv[LAT-1] && i_fsm_y && !w_abort;

  fsm_seq_buf #(.DEPTH(DEPTH)) u_buf (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_clr),
    .i_wr     (w_wr),
    .i_sym    (i_wr_sym),
    .i_rd_ptr (w_ptr_nxt),
    .o_rd_sym (w_rd_sym),
    .o_len    (w_len),
    .o_full   (w_full)
  );

  always_comb begin
    w_nxt      = r_state;
    w_ptr_nxt  = r_ptr;
    w_dcnt_nxt = r_dcnt;
    unique case (r_state)
      IDLE:  if (w_go) w_nxt = (w_len_eff != '0) ? CLEAR : DONE;
      CLEAR: begin
        w_nxt     = RUN;
        w_ptr_nxt = '0;
      end
      RUN: begin
        w_ptr_nxt = r_ptr + 1'b1;
        if ({1'b0, r_ptr} == w_len - 1'b1) begin
          w_nxt      = DRAIN;
          w_dcnt_nxt = '0;
        end
      end
      DRAIN: begin
        w_dcnt_nxt = r_dcnt + 1'b1;
        if (r_dcnt == 2'(LAT - 1)) w_nxt = DONE;
      end
      default: w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = DONE;
  end

  // outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_dcnt      <= '0;
      r_pv        <= '0;
      for (int i = 0; i < LAT; i++) r_pi[i] <= '0;
      o_fsm_x     <= 1'b0;
      o_fsm_z     <= 1'b0;
      o_fsm_rst   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_aborted   <= 1'b0;
      o_hit_cnt   <= '0;
      o_first_hit <= '0;
      o_hit_valid <= 1'b0;
      o_wr_err    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_ptr     <= w_ptr_nxt;
      r_dcnt    <= w_dcnt_nxt;
      o_fsm_rst <= w_nxt == CLEAR;
      o_fsm_x   <= (w_nxt == RUN) && |(w_rd_sym & SYM_X);
      o_fsm_z   <= (w_nxt == RUN) && |(w_rd_sym & SYM_Z);
      o_busy    <= w_nxt inside {CLEAR, RUN, DRAIN};
      o_done    <= w_nxt == DONE;
      r_pv[0]   <= (r_state == RUN) && !w_abort;
      r_pi[0]   <= r_ptr;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i] <= r_pv[i-1] && !w_abort;
        r_pi[i] <= r_pi[i-1];
      end
      o_wr_err  <= w_clr ? 1'b0 : (i_wr_en && (!w_idle || w_full)) ? 1'b1 : w_go ? 1'b0 : o_wr_err;
      if (w_go) begin
        o_hit_cnt   <= '0;
        o_hit_valid <= 1'b0;
        o_first_hit <= '0;
        o_aborted   <= 1'b0;
      end else begin
        if (w_abort) o_aborted <= 1'b1;
        if (w_score) begin
          o_hit_cnt <= (o_hit_cnt == '1) ? o_hit_cnt : o_hit_cnt + 1'b1;
          if (!o_hit_valid) begin
            o_first_hit <= r_pi[LAT-1];
            o_hit_valid <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl: randomized scoreboard bench; a mask-driven recognizer model feeds fsm_y
module tb_fsm_seq_ctrl;
  localparam int DEPTH = 8, LAT = 2, CW = 3, IW = 3, SAT = (1 << CW) - 1;
  typedef struct { int cyc; int hc; int fh; int hv; int ab; int busyn; int rsum; } exp_t;

  logic clk = 0, rst_n = 0;
  logic wr_en = 0, clr = 0, start = 0, abort = 0, fsm_y = 0;
  logic [1:0] wr_sym = 0;
  logic fsm_x, fsm_z, fsm_rst, busy, done, aborted, hit_valid, wr_err;
  logic [CW-1:0] hit_cnt;
  logic [IW-1:0] first_hit;
  int n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0, busy_n = 0, rst_sum = 0;
  logic [3:0] mask = 0;
  logic [1:0] hist [LAT+1] = '{default: '0};
  logic [1:0] bq [$];
  bit err_m = 0;
  exp_t exp_q [$];
  exp_t got;

  fsm_seq_ctrl #(.DEPTH(DEPTH), .LAT(LAT), .CW(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_sym(wr_sym), .i_clr(clr),
    .i_start(start), .i_abort(abort), .i_fsm_y(fsm_y), .o_fsm_x(fsm_x), .o_fsm_z(fsm_z),
    .o_fsm_rst(fsm_rst), .o_busy(busy), .o_done(done), .o_aborted(aborted),
    .o_hit_cnt(hit_cnt), .o_first_hit(first_hit), .o_hit_valid(hit_valid), .o_wr_err(wr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // recognizer model: y in cycle t+LAT reflects mask[symbol driven in cycle t]
  always @(negedge clk) begin
    for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {fsm_x, fsm_z};
    fsm_y = mask[hist[LAT]];
  end

  // monitor: pops the expected result whenever the DUT pulses done
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_n = 0;
      rst_sum = 0;
    end else begin
      if (fsm_rst) rst_sum += cyc - t0;
      if (busy) busy_n++;
      if (done) begin
        if (exp_q.size() == 0) chk("spurious_done", int'(done), 0);
        else begin
          got = exp_q.pop_front();
          chk("done_cycle", cyc - t0, got.cyc);
          chk("hit_cnt", int'(hit_cnt), got.hc);
          chk("first_hit", int'(first_hit), got.fh);
          chk("hit_valid", int'(hit_valid), got.hv);
          chk("aborted", int'(aborted), got.ab);
          chk("busy_cycles", busy_n, got.busyn);
          chk("fsm_rst_cycle", rst_sum, got.rsum);
        end
        busy_n = 0;
        rst_sum = 0;
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk(nm, int'({fsm_x, fsm_z, fsm_rst, busy, done, aborted, hit_cnt, first_hit, hit_valid, wr_err}), 0);
  endtask

  task automatic put(input logic [1:0] s);
    @(negedge clk);
    wr_en = 1;
    wr_sym = s;
    if (bq.size() < DEPTH) bq.push_back(s);
    else err_m = 1;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic do_clr;
    @(negedge clk);
    clr = 1;
    bq.delete();
    err_m = 0;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic do_run(input int ab_at, input bit wr_at_start, input bit noise);
    exp_t e;
    int len, hits, first, dc, rel;
    bit ab_eff, nz;
    logic [1:0] s;
    @(negedge clk);
    if (wr_at_start && bq.size() < DEPTH) begin
      s = 2'($urandom);
      wr_en = 1;
      wr_sym = s;
      bq.push_back(s);
    end
    len = bq.size();
    dc = (len == 0) ? 1 : len + 2 + LAT;
    ab_eff = ab_at > 0 && ab_at < dc;
    hits = 0;
    first = 0;
    for (int i = 0; i < len; i++)
      if (mask[bq[i]] && (!ab_eff || i + 2 + LAT < ab_at)) begin
        if (hits == 0) first = i;
        hits++;
      end
    e.cyc = ab_eff ? ab_at + 1 : dc;
    e.hc = hits > SAT ? SAT : hits;
    e.fh = first;
    e.hv = int'(hits > 0);
    e.ab = int'(ab_eff);
    e.busyn = e.cyc - 1;
    e.rsum = len > 0 ? 1 : 0;
    exp_q.push_back(e);
    err_m = 0;
    start = 1;
    t0 = cyc;
    for (rel = 1; rel <= e.cyc + 1; rel++) begin
      @(negedge clk);
      nz = noise && rel < e.cyc;
      start = nz && $urandom_range(0, 3) == 0;
      clr = nz && $urandom_range(0, 3) == 0;
      wr_en = nz && (rel == 2 || $urandom_range(0, 3) == 0);
      wr_sym = 2'($urandom);
      if (wr_en) err_m = 1;
      abort = (ab_at > 0 && rel == ab_at);
    end
    {start, clr, wr_en, abort} = '0;
    chk("done_seen", exp_q.size(), 0);
    exp_q.delete();
    chk("idle_xz", int'({fsm_x, fsm_z, busy}), 0);
    chk("wr_err", int'(wr_err), int'(err_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1;
    // directed: only symbol 11 (index 1) is recognized
    put(2'b01); put(2'b11); put(2'b00); put(2'b10);
    mask = 4'b1000;
    do_run(0, 0, 0);
    do_clr;
    do_run(0, 0, 0);
    // overfill, saturate, then replay with results reset
    repeat (9) put(2'($urandom));
    chk("wr_err_full", int'(wr_err), 1);
    mask = 4'hF;
    do_run(0, 0, 0);
    mask = 4'h0;
    do_run(0, 0, 0);
    put(2'b11);
    chk("wr_err_set_again", int'(wr_err), int'(err_m));
    do_clr;
    chk("wr_err_clr", int'(wr_err), 0);
    // aborts in a len-6 run, and an abort landing on the done cycle
    mask = 4'hF;
    repeat (6) put(2'($urandom));
    do_run(3, 0, 0);
    do_run(7, 0, 0);
    do_run(1, 0, 0);
    do_run(10, 0, 1);
    // randomized runs with writes during busy, start+write, ignored start/clr
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) do_clr;
      repeat ($urandom_range(0, 4)) put(2'($urandom));
      mask = 4'($urandom);
      do_run($urandom_range(0, 2) == 0 ? $urandom_range(1, 14) : 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    // reset in the middle of a run
    do_clr;
    repeat (5) put(2'($urandom));
    @(negedge clk);
    start = 1;
    t0 = cyc;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 0;
    #1 chk_zero("async_reset_outputs");
    bq.delete();
    err_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    do_run(0, 0, 0);
    mask = 4'b0110;
    put(2'b01); put(2'b00); put(2'b10); put(2'b11); put(2'b10);
    do_run(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
